// File: rtl/prog_rom_loadable.sv
// Loadable instruction memory: a valid/ready loader fills the array, and the CPU
// fetches through a registered read port. Any fetch at or beyond the loaded
// program length returns NOP.
module prog_rom_loadable #(
    parameter int unsigned AW  = 6,
    parameter int unsigned W   = 10,
    parameter logic [W-1:0] NOP = '0
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [W-1:0]  ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic [AW-1:0] ad,
    output logic [W-1:0]  q,
    output logic          q_valid,
    output logic          loaded,
    output logic [AW:0]   words,
    output logic          err_ovf
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] ptr;
    logic          accept;
    logic          at_end;
    logic          fetch_hit;
    logic [W-1:0]  mem [DEPTH];

    // The loader handshake depends only on the current state.
    assign ld_ready = (state == ST_LOAD);
    assign at_end   = (ptr == PTR_MAX);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake qualification and fetch hit; a restart beats a handshake.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fetch_hit  = 1'b0;
        accept     = (state == ST_LOAD) && ld_valid && !load_start;
        fetch_hit  = (state == ST_RUN) && ({1'b0, ad} < words);
        case (state)
            ST_EMPTY, ST_RUN: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                end else if (accept && (ld_last || at_end)) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Program storage; intentionally not reset, since words=0 masks stale content.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[ptr] <= ld_data;
        end
    end

    // Load bookkeeping: pointer, length, status flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr     <= '0;
            words   <= '0;
            loaded  <= 1'b0;
            err_ovf <= 1'b0;
        end else if (load_start) begin
            ptr     <= '0;
            words   <= '0;
            loaded  <= 1'b0;
            err_ovf <= 1'b0;
        end else if (accept) begin
            words <= words + (AW + 1)'(1);
            if (ld_last) begin
                loaded <= 1'b1;
            end else if (at_end) begin
                loaded  <= 1'b1;
                err_ovf <= 1'b1;
            end
            if (!at_end) begin
                ptr <= ptr + AW'(1);
            end
        end
    end

    // Registered fetch port.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q       <= NOP;
            q_valid <= 1'b0;
        end else begin
            q       <= fetch_hit ? mem[ad] : NOP;
            q_valid <= fetch_hit;
        end
    end

endmodule

// File: tb/tb_prog_rom_loadable.sv
// Directed bench for prog_rom_loadable, with a behavioural model and a fetch scoreboard.
module tb_prog_rom_loadable;

    localparam int unsigned AW = 6;
    localparam int unsigned W  = 10;
    localparam logic [W-1:0] NOP_W = '0;

    logic          clk;
    logic          n_rst;
    logic          load_start;
    logic          ld_valid;
    logic [W-1:0]  ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic [AW-1:0] ad;
    logic [W-1:0]  q;
    logic          q_valid;
    logic          loaded;
    logic [AW:0]   words;
    logic          err_ovf;

    typedef struct packed {
        logic         v;
        logic [W-1:0] q;
    } exp_t;

    exp_t sb[$];

    int           vectors;
    int           miscompares;
    int           hs_count;
    int           m_state;
    int           m_words;
    int           m_ptr;
    logic         m_loaded;
    logic         m_err;
    logic [W-1:0] m_mem [64];

    prog_rom_loadable #(.AW(AW), .W(W), .NOP(NOP_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .load_start (load_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ad         (ad),
        .q          (q),
        .q_valid    (q_valid),
        .loaded     (loaded),
        .words      (words),
        .err_ovf    (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: predict fetch from pre-edge model, advance model, compare after edge.
    task automatic step();
        exp_t e;
        logic hit;
        chk("ld_ready", 32'(ld_ready), 32'(m_state == 1));
        hit = (m_state == 2) && (int'(ad) < m_words);
        e.v = hit;
        e.q = hit ? m_mem[ad] : NOP_W;
        sb.push_back(e);
        if (load_start) begin
            m_state = 1; m_ptr = 0; m_words = 0; m_loaded = 1'b0; m_err = 1'b0;
        end else if (m_state == 1 && ld_valid) begin
            m_mem[m_ptr] = ld_data;
            m_words++;
            hs_count++;
            if (ld_last) begin
                m_state = 2; m_loaded = 1'b1;
            end else if (m_ptr == 63) begin
                m_state = 2; m_loaded = 1'b1; m_err = 1'b1;
            end else begin
                m_ptr++;
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            chk("q", 32'(q), 32'(e.q));
            chk("q_valid", 32'(q_valid), 32'(e.v));
        end
        chk("loaded", 32'(loaded), 32'(m_loaded));
        chk("words", 32'(words), 32'(m_words));
        chk("err_ovf", 32'(err_ovf), 32'(m_err));
    endtask

    task automatic start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input int a);
        ad = AW'(a);
        step();
    endtask

    task automatic pulse_reset();
        n_rst = 1'b0;
        m_state = 0; m_words = 0; m_ptr = 0; m_loaded = 1'b0; m_err = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        chk("rst_words", 32'(words), 32'(0));
        chk("rst_loaded", 32'(loaded), 32'(0));
        chk("rst_q", 32'(q), 32'(0));
        chk("rst_q_valid", 32'(q_valid), 32'(0));
        chk("rst_ld_ready", 32'(ld_ready), 32'(0));
        chk("rst_err_ovf", 32'(err_ovf), 32'(0));
    endtask

    initial begin
        vectors = 0; miscompares = 0; hs_count = 0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        n_rst = 1'b0; load_start = 1'b0; ld_valid = 1'b0;
        ld_data = '0; ld_last = 1'b0; ad = '0;
        m_state = 0; m_words = 0; m_ptr = 0; m_loaded = 1'b0; m_err = 1'b0;

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();
        fetch(0);
        chk("empty_fetch_q_valid", 32'(q_valid), 32'(0));

        // Four-word program; fetch issued with the last word still sees NOP.
        start();
        send({4'b1000, 6'd60}, 1'b0);
        send({4'b0000, 6'd0}, 1'b0);
        send({4'b0110, 6'd1}, 1'b0);
        ad = '0;
        send({4'b1100, 6'd2}, 1'b1);
        chk("prog4_loaded", 32'(loaded), 32'(1));
        chk("prog4_words", 32'(words), 32'(4));
        chk("prog4_same_cycle_fetch", 32'(q_valid), 32'(0));
        fetch(0);
        chk("prog4_q0", 32'(q), 32'(10'h23C));
        chk("prog4_q0_valid", 32'(q_valid), 32'(1));
        fetch(3);
        chk("prog4_q3", 32'(q), 32'(10'h302));
        fetch(4);
        chk("prog4_q4", 32'(q), 32'(0));
        chk("prog4_q4_valid", 32'(q_valid), 32'(0));

        // Randomly throttled loader.
        start();
        hs_count = 0;
        for (int i = 0; i < 40; i++) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = W'($urandom);
            ld_last  = 1'b0;
            step();
        end
        send(10'h2A5, 1'b1);
        chk("rand_words", 32'(words), 32'(hs_count));
        for (int a = 0; a <= hs_count; a++) fetch(a);

        // Loader traffic outside LOAD is ignored.
        ld_valid = 1'b1;
        ld_data  = 10'h3FF;
        step();
        ld_valid = 1'b0;
        chk("run_ignore_words", 32'(words), 32'(hs_count));

        // Fill the whole memory without LD_LAST.
        start();
        for (int i = 0; i < 64; i++) send(W'(i * 7 + 3), 1'b0);
        chk("ovf_err", 32'(err_ovf), 32'(1));
        chk("ovf_loaded", 32'(loaded), 32'(1));
        chk("ovf_words", 32'(words), 32'(64));
        chk("ovf_ld_ready", 32'(ld_ready), 32'(0));
        fetch(63);
        chk("ovf_q63", 32'(q), 32'(10'h1BC));
        chk("ovf_q63_valid", 32'(q_valid), 32'(1));
        ad = 6'd63;
        start();
        chk("restart_cycle_fetch_valid", 32'(q_valid), 32'(1));
        chk("restart_err_clr", 32'(err_ovf), 32'(0));
        chk("restart_loaded_clr", 32'(loaded), 32'(0));
        fetch(63);
        chk("restart_next_fetch_valid", 32'(q_valid), 32'(0));

        // Restart colliding with the third handshake.
        send(10'h011, 1'b0);
        send(10'h022, 1'b0);
        ld_valid   = 1'b1;
        ld_data    = 10'h033;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        ld_valid   = 1'b0;
        chk("collide_words", 32'(words), 32'(0));
        send(10'h155, 1'b1);
        chk("collide_words_after", 32'(words), 32'(1));
        fetch(0);
        chk("collide_q0", 32'(q), 32'(10'h155));
        fetch(1);
        chk("collide_q1_valid", 32'(q_valid), 32'(0));

        // Reset in the middle of a load.
        start();
        for (int i = 0; i < 5; i++) send(W'(10'h100 + i), 1'b0);
        pulse_reset();
        for (int a = 0; a < 5; a++) begin
            fetch(a);
            chk("midrst_q_valid", 32'(q_valid), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
